// File: rtl/psum_acc_bank.sv
// Ping-pong partial-sum accumulator: saturating per-lane overwrite/accumulate into the
// write bank, concurrent pipelined readout of the other bank with optional ReLU.
`timescale 1ns/1ps
module psum_acc_bank #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 2048,
    parameter int addr_w  = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [col*psum_bw-1:0] in_data,
    input  logic [addr_w-1:0]      in_addr,
    input  logic                   in_acc,
    input  logic                   swap,
    input  logic                   rd_req,
    input  logic [addr_w-1:0]      rd_addr,
    input  logic                   relu_en,
    output logic                   out_valid,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   wbank,
    output logic                   busy
);

    localparam int DW = col * psum_bw;

    logic [DW-1:0] bank_mem [2][depth];

    logic              accept;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_acc_q, s1_acc_d;
    logic              s1_bank_q, s1_bank_d;
    logic [addr_w-1:0] s1_addr_q, s1_addr_d;
    logic [DW-1:0]     s1_data_q, s1_data_d;
    logic [DW-1:0]     s1_old_q, s1_old_d;
    logic [DW-1:0]     s1_sum, s1_result;
    logic [psum_bw:0]  lane_ext;

    logic              swap_pend_q, swap_pend_d;
    logic              wbank_q, wbank_d;

    logic              rq_valid_q, rq_valid_d;
    logic              rq_relu_q, rq_relu_d;
    logic              rq_bank_q, rq_bank_d;
    logic [addr_w-1:0] rq_addr_q, rq_addr_d;
    logic              r1_valid_q, r1_valid_d;
    logic              r1_relu_q, r1_relu_d;
    logic [DW-1:0]     r1_data_q, r1_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;

    assign accept    = in_valid && !swap_pend_q;
    assign in_ready  = !swap_pend_q;
    assign busy      = s1_valid_q || swap_pend_q;
    assign wbank     = wbank_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Per-lane saturating add at psum_bw+1 bits; overflow picks the rail from the extended sign.
    always_comb begin
        s1_sum   = '0;
        lane_ext = '0;
        for (int unsigned k = 0; k < col; k++) begin
            lane_ext = {s1_old_q[k*psum_bw+psum_bw-1], s1_old_q[k*psum_bw +: psum_bw]}
                     + {s1_data_q[k*psum_bw+psum_bw-1], s1_data_q[k*psum_bw +: psum_bw]};
            if (lane_ext[psum_bw] != lane_ext[psum_bw-1])
                s1_sum[k*psum_bw +: psum_bw] = {lane_ext[psum_bw], {(psum_bw-1){~lane_ext[psum_bw]}}};
            else
                s1_sum[k*psum_bw +: psum_bw] = lane_ext[psum_bw-1:0];
        end
        s1_result = s1_acc_q ? s1_sum : s1_data_q;
    end

    always_comb begin
        s1_valid_d = accept;
        s1_acc_d   = s1_acc_q;
        s1_bank_d  = s1_bank_q;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        if (accept) begin
            s1_acc_d  = in_acc;
            s1_bank_d = wbank_q;
            s1_addr_d = in_addr;
            s1_data_d = in_data;
        end
        // S1 is writing the address S0 reads this edge: take its result, not the stale word.
        if (s1_valid_q && s1_bank_q == wbank_q && s1_addr_q == in_addr)
            s1_old_d = s1_result;
        else
            s1_old_d = bank_mem[wbank_q][in_addr];

        swap_pend_d = swap_pend_q;
        wbank_d     = wbank_q;
        if (swap_pend_q) begin
            if (!s1_valid_q) begin
                swap_pend_d = 1'b0;
                wbank_d     = ~wbank_q;
            end
        end else if (swap) begin
            swap_pend_d = 1'b1;
        end

        rq_valid_d = rd_req;
        rq_relu_d  = rq_relu_q;
        rq_bank_d  = rq_bank_q;
        rq_addr_d  = rq_addr_q;
        if (rd_req) begin
            rq_relu_d = relu_en;
            rq_bank_d = ~wbank_q;
            rq_addr_d = rd_addr;
        end
        r1_valid_d = rq_valid_q;
        r1_relu_d  = rq_relu_q;
        r1_data_d  = bank_mem[rq_bank_q][rq_addr_q];

        out_valid_d = r1_valid_q;
        out_data_d  = out_data_q;
        if (r1_valid_q) begin
            for (int unsigned k = 0; k < col; k++) begin
                if (r1_relu_q && r1_data_q[k*psum_bw+psum_bw-1])
                    out_data_d[k*psum_bw +: psum_bw] = '0;
                else
                    out_data_d[k*psum_bw +: psum_bw] = r1_data_q[k*psum_bw +: psum_bw];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= 1'b0;
            s1_bank_q   <= 1'b0;
            s1_addr_q   <= '0;
            s1_data_q   <= '0;
            swap_pend_q <= 1'b0;
            wbank_q     <= 1'b0;
            rq_valid_q  <= 1'b0;
            rq_relu_q   <= 1'b0;
            rq_bank_q   <= 1'b0;
            rq_addr_q   <= '0;
            r1_valid_q  <= 1'b0;
            r1_relu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_acc_q    <= s1_acc_d;
            s1_bank_q   <= s1_bank_d;
            s1_addr_q   <= s1_addr_d;
            s1_data_q   <= s1_data_d;
            swap_pend_q <= swap_pend_d;
            wbank_q     <= wbank_d;
            rq_valid_q  <= rq_valid_d;
            rq_relu_q   <= rq_relu_d;
            rq_bank_q   <= rq_bank_d;
            rq_addr_q   <= rq_addr_d;
            r1_valid_q  <= r1_valid_d;
            r1_relu_q   <= r1_relu_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage and its read ports carry no reset; a write is gated by S1 valid, which reset clears.
    always_ff @(posedge clk) begin
        if (s1_valid_q)
            bank_mem[s1_bank_q][s1_addr_q] <= s1_result;
        if (accept)
            s1_old_q <= s1_old_d;
        if (rq_valid_q)
            r1_data_q <= r1_data_d;
    end

endmodule

// File: tb/tb_psum_acc_bank.sv
// Randomized and directed bench for psum_acc_bank against a transaction-level bank model.
`timescale 1ns/1ps
module tb_psum_acc_bank;

    localparam int COL   = 4;
    localparam int PBW   = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = COL * PBW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_acc, swap, rd_req, relu_en;
    logic          out_valid, wbank, busy;
    logic [DW-1:0] in_data, out_data;
    logic [AW-1:0] in_addr, rd_addr;

    psum_acc_bank #(.col(COL), .psum_bw(PBW), .depth(DEPTH), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_acc(in_acc), .swap(swap),
        .rd_req(rd_req), .rd_addr(rd_addr), .relu_en(relu_en), .out_valid(out_valid),
        .out_data(out_data), .wbank(wbank), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       rq[$];
    logic [DW-1:0] m_mem [2][DEPTH];
    logic          m_wbank, m_pend, m_s1;
    logic          m_last_bank;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_old;
    int            cyc, n_tests, n_fail, n_rd_seen;
    logic [DW-1:0] last_out;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int lane_val(input logic [DW-1:0] v, input int k);
        logic [PBW-1:0] l;
        l = v[k*PBW +: PBW];
        return l[PBW-1] ? int'(l) - (1 << PBW) : int'(l);
    endfunction

    function automatic logic [DW-1:0] sat_vec(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        int x;
        r = '0;
        for (int k = 0; k < COL; k++) begin
            x = lane_val(a, k) + lane_val(b, k);
            if (x > (1 << (PBW-1)) - 1) x = (1 << (PBW-1)) - 1;
            if (x < -(1 << (PBW-1)))    x = -(1 << (PBW-1));
            r[k*PBW +: PBW] = x[PBW-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] relu_vec(input logic [DW-1:0] a);
        logic [DW-1:0] r;
        r = a;
        for (int k = 0; k < COL; k++)
            if (lane_val(a, k) < 0) r[k*PBW +: PBW] = '0;
        return r;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [PBW-1:0] x);
        logic [DW-1:0] r;
        for (int k = 0; k < COL; k++) r[k*PBW +: PBW] = x;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] r;
        logic [31:0]   u;
        for (int k = 0; k < COL; k++) begin
            u = $urandom;
            r[k*PBW +: PBW] = u[PBW-1:0];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] rnd_addr(input int lim);
        logic [31:0] u;
        u = $urandom_range(0, lim - 1);
        return u[AW-1:0];
    endfunction

    // Apply the effect of the coming edge to the model, clock, then compare outputs.
    task automatic cycle();
        rd_exp_t it;
        logic    acc_now;
        acc_now = in_valid && !m_pend;
        if (rd_req) begin
            it.due  = cyc + 3;
            it.data = relu_en ? relu_vec(m_mem[!m_wbank][rd_addr]) : m_mem[!m_wbank][rd_addr];
            rq.push_back(it);
        end
        if (acc_now) begin
            m_last_bank = m_wbank;
            m_last_addr = in_addr;
            m_last_old  = m_mem[m_wbank][in_addr];
            m_mem[m_wbank][in_addr] = in_acc ? sat_vec(m_last_old, in_data) : in_data;
        end
        if (m_pend) begin
            if (!m_s1) begin
                m_pend  = 1'b0;
                m_wbank = !m_wbank;
            end
        end else if (swap) begin
            m_pend = 1'b1;
        end
        m_s1 = acc_now;

        @(posedge clk);
        #1;
        cyc++;
        in_valid = 1'b0;
        swap     = 1'b0;
        rd_req   = 1'b0;

        check("in_ready", DW'(in_ready), DW'(!m_pend));
        check("wbank", DW'(wbank), DW'(m_wbank));
        check("busy", DW'(busy), DW'(m_s1 || m_pend));
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("out_valid", DW'(out_valid), DW'(1));
            check("out_data", out_data, rq[0].data);
            void'(rq.pop_front());
        end else begin
            check("out_valid_idle", DW'(out_valid), DW'(0));
        end
        if (out_valid) begin
            last_out = out_data;
            n_rd_seen++;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic acc);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_acc   = acc;
        cycle();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic relu);
        rd_req  = 1'b1;
        rd_addr = a;
        relu_en = relu;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_swap();
        swap = 1'b1;
        cycle();
        for (int i = 0; i < 4 && !in_ready; i++) cycle();
        check("swap_done", DW'(in_ready), DW'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic          old_wb;
        logic [DW-1:0] v, v0, v1, exp_v, old11;

        n_tests = 0; n_fail = 0; cyc = 0; n_rd_seen = 0; last_out = '0;
        reset = 1'b1; in_valid = 1'b0; in_acc = 1'b0; swap = 1'b0;
        rd_req = 1'b0; relu_en = 1'b0; in_data = '0; in_addr = '0; rd_addr = '0;
        m_wbank = 1'b0; m_pend = 1'b0; m_s1 = 1'b0;
        m_last_bank = 1'b0; m_last_addr = '0; m_last_old = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", DW'(in_ready), DW'(1));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_wbank", DW'(wbank), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        reset = 1'b0;

        for (int a = 0; a < DEPTH; a++) wr(AW'(a), rnd_vec(), 1'b0);
        do_swap();
        for (int a = 0; a < DEPTH; a++) wr(AW'(a), rnd_vec(), 1'b0);
        do_swap();

        // Overwrite then read with exact latency
        wr(6'd5, fill(16'h0010), 1'b0);
        do_swap();
        rd(6'd5, 1'b0);
        idle(1);
        check("rd_lat_early", DW'(out_valid), DW'(0));
        idle(1);
        check("rd_lat", DW'(out_valid), DW'(1));
        check("ovr_rd", last_out, fill(16'h0010));

        // Back-to-back accumulates through the forwarding path
        wr(6'd7, fill(16'h0001), 1'b0);
        wr(6'd7, fill(16'h0003), 1'b1);
        wr(6'd7, fill(16'h0004), 1'b1);
        wr(6'd7, fill(16'h0005), 1'b1);
        do_swap();
        rd(6'd7, 1'b0);
        idle(2);
        check("acc_fwd", last_out, fill(16'h000D));

        // Saturation and per-request ReLU
        v0 = '0; v0[0 +: PBW] = 16'h7FF0; v0[PBW +: PBW] = 16'h8010;
        v1 = '0; v1[0 +: PBW] = 16'h0020; v1[PBW +: PBW] = 16'hFFE0;
        wr(6'd9, v0, 1'b0);
        wr(6'd9, v1, 1'b1);
        do_swap();
        rd(6'd9, 1'b1);
        rd(6'd9, 1'b0);
        idle(1);
        exp_v = '0; exp_v[0 +: PBW] = 16'h7FFF;
        check("sat_relu", last_out, exp_v);
        idle(1);
        exp_v[PBW +: PBW] = 16'h8000;
        check("sat_raw", last_out, exp_v);

        // Swap together with an accepted write
        old_wb = m_wbank;
        v = rnd_vec();
        in_valid = 1'b1; in_addr = 6'd20; in_data = v; in_acc = 1'b0; swap = 1'b1;
        cycle();
        check("swapw_ready0", DW'(in_ready), DW'(0));
        cycle();
        check("swapw_ready1", DW'(in_ready), DW'(0));
        cycle();
        check("swapw_ready2", DW'(in_ready), DW'(1));
        check("swapw_wbank", DW'(wbank), DW'(!old_wb));
        rd(6'd20, 1'b0);
        idle(2);
        check("swapw_oldbank", last_out, v);

        // Repeated swap requests while pending toggle once
        old_wb = m_wbank;
        in_valid = 1'b1; in_addr = 6'd21; in_data = rnd_vec(); in_acc = 1'b0; swap = 1'b1;
        cycle();
        swap = 1'b1;
        cycle();
        swap = 1'b1;
        cycle();
        idle(2);
        check("dbl_swap", DW'(wbank), DW'(!old_wb));

        // Accumulate into the write bank while streaming reads from the other
        if (!m_wbank) do_swap();
        n_rd_seen = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_acc = 1'b1; in_addr = AW'(30 + i % 4); in_data = rnd_vec();
            rd_req = 1'b1; rd_addr = AW'(i); relu_en = 1'b0;
            cycle();
        end
        idle(2);
        check("conc_reads", DW'(n_rd_seen), DW'(16));
        do_swap();
        for (int a = 30; a < 34; a++) rd(AW'(a), 1'b0);
        idle(2);

        // Randomized mix of writes, accumulates, swaps and reads
        for (int i = 0; i < 500; i++) begin
            logic [31:0] u;
            u = $urandom;
            in_valid = u[0] | u[1];
            in_acc   = u[2];
            in_addr  = rnd_addr(8);
            in_data  = rnd_vec();
            swap     = ($urandom_range(0, 15) == 0);
            rd_req   = u[3];
            rd_addr  = rnd_addr(DEPTH);
            relu_en  = u[4];
            cycle();
        end
        idle(3);

        // Async reset with S1 and the output stage occupied
        if (m_wbank) do_swap();
        old11 = m_mem[0][11];
        rd(6'd3, 1'b0);
        idle(1);
        wr(6'd11, ~old11, 1'b0);
        check("pre_rst_busy", DW'(busy), DW'(1));
        check("pre_rst_ov", DW'(out_valid), DW'(1));
        reset = 1'b1;
        #1;
        check("arst_out_valid", DW'(out_valid), DW'(0));
        check("arst_busy", DW'(busy), DW'(0));
        check("arst_wbank", DW'(wbank), DW'(0));
        check("arst_in_ready", DW'(in_ready), DW'(1));
        if (m_s1) m_mem[m_last_bank][m_last_addr] = m_last_old;
        rq.delete();
        m_pend = 1'b0; m_s1 = 1'b0; m_wbank = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        idle(1);
        do_swap();
        rd(6'd11, 1'b0);
        idle(2);
        check("no_partial_wr", last_out, old11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
